snn_mem_sequencer: RTL

Owns the single-port synaptic/neuron memory of the SNN accelerator and shares it between two requesters: the host loader, which writes weights from the servant SoC, and the inference engine, which streams words out in address order. Only one session runs at a time. The block keeps its own sequential address counter (0..DEPTH-1) and drives the memory port directly. The read stream carries valid/ready backpressure at one word per cycle.

---
 rtl/snn_mem_sequencer_if.sv | 70 +++++++
 rtl/snn_mem_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/snn_mem_sequencer_if.sv
// Signal bundle of snn_mem_sequencer: loader handshake, inference stream,
// status flags and the single-port memory bus. The sequencer uses the slave
// modport. The environment (host loader, inference engine, memory) uses master.
interface snn_mem_sequencer_if #(
    parameter int DEPTH = 8192,
    parameter int DW    = 16
);
    // Number of right shifts needed to reach zero (14 for 8192).
    function automatic int clogb2(input int depth);
        int d;
        int n;
        d = depth;
        n = 0;
        while (d > 0) begin
            d = d >> 1;
            n = n + 1;
        end
        return n;
    endfunction

    localparam int AW = clogb2(DEPTH);

    // Host loader
    logic          ld_start;
    logic          ld_valid;
    logic [DW-1:0] ld_data;
    logic          ld_end;
    logic          ld_ready;
    logic          ld_done;
    logic [AW:0]   ld_count;

    // Inference read stream
    logic          run_start;
    logic [AW:0]   run_len;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_ready;
    logic          run_done;

    // Status
    logic          busy;
    logic          collision;

    // Memory port
    logic          mem_we;
    logic          mem_re;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  ld_start, ld_valid, ld_data, ld_end,
        input  run_start, run_len, rd_ready,
        input  mem_rdata,
        output ld_ready, ld_done, ld_count,
        output rd_valid, rd_data, run_done,
        output busy, collision,
        output mem_we, mem_re, mem_addr, mem_wdata
    );

    modport master (
        output ld_start, ld_valid, ld_data, ld_end,
        output run_start, run_len, rd_ready,
        output mem_rdata,
        input  ld_ready, ld_done, ld_count,
        input  rd_valid, rd_data, run_done,
        input  busy, collision,
        input  mem_we, mem_re, mem_addr, mem_wdata
    );
endinterface

// File: rtl/snn_mem_sequencer.sv
// Arbitrates the single-port synaptic/neuron memory between the host loader
// (sequential writes) and the inference engine (sequential reads streamed out
// through a 2-entry FIFO with valid/ready backpressure). One session at a time.
module snn_mem_sequencer #(
    parameter int DEPTH = 8192,
    parameter int DW    = 16
) (
    input  logic               clk,
    input  logic               rst,
    snn_mem_sequencer_if.slave bus
);
    function automatic int clogb2(input int depth);
        int d;
        int n;
        d = depth;
        n = 0;
        while (d > 0) begin
            d = d >> 1;
            n = n + 1;
        end
        return n;
    endfunction

    localparam int          AW       = clogb2(DEPTH);
    localparam logic [AW:0] DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW:0] LAST_W   = DEPTH_W - (AW+1)'(1);
    localparam logic [AW:0] ONE_W    = (AW+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW:0]   cnt_q, cnt_d;            // address counter / reads issued
    logic [AW:0]   len_q, len_d;            // clamped sweep length
    logic [AW:0]   ld_count_q, ld_count_d;
    logic          ld_done_q, ld_done_d;
    logic          run_done_q, run_done_d;
    logic          collision_q, collision_d;
    logic          inflight_q, inflight_d;  // mem_re was asserted last cycle
    logic [1:0]    occ_q, occ_d;            // FIFO occupancy 0..2
    logic          rd_ptr_q, rd_ptr_d;
    logic          wr_ptr_q, wr_ptr_d;
    logic [DW-1:0] fifo_q [2];

    logic          wr_en;
    logic          rd_en;
    logic          pop;
    logic          push;
    logic          rd_valid_w;
    logic [2:0]    level;
    logic [2:0]    limit;

    assign rd_valid_w = (occ_q != 2'd0);
    assign push       = inflight_q;
    assign level      = {1'b0, occ_q} + {2'b00, inflight_q};

    // Next-state, memory-port strobes and FIFO bookkeeping.
    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        ld_count_d  = ld_count_q;
        ld_done_d   = 1'b0;
        run_done_d  = 1'b0;
        collision_d = 1'b0;
        wr_en       = 1'b0;
        rd_en       = 1'b0;
        pop         = 1'b0;
        limit       = 3'd1;

        case (state_q)
            S_IDLE: begin
                cnt_d       = '0;
                collision_d = bus.ld_start & bus.run_start;
                if (bus.ld_start) begin
                    state_d    = S_LOAD;
                    ld_count_d = '0;
                end else if (bus.run_start) begin
                    len_d   = (bus.run_len > DEPTH_W) ? DEPTH_W : bus.run_len;
                    state_d = (bus.run_len == '0) ? S_FLUSH : S_RUN;
                end
            end

            S_LOAD: begin
                collision_d = bus.ld_start | bus.run_start;
                wr_en       = bus.ld_valid;
                if (wr_en) begin
                    cnt_d      = cnt_q + ONE_W;
                    ld_count_d = ld_count_q + ONE_W;
                end
                // A word presented together with ld_end is still written.
                if ((wr_en && (cnt_q == LAST_W)) || bus.ld_end) begin
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                    ld_done_d = 1'b1;
                end
            end

            S_RUN: begin
                collision_d = bus.ld_start | bus.run_start;
                pop         = rd_valid_w & bus.rd_ready;
                limit       = 3'd1 + {2'b00, pop};
                // Issue only if the returning word is guaranteed a FIFO slot.
                rd_en       = (cnt_q < len_q) && (level <= limit);
                if (rd_en) begin
                    cnt_d = cnt_q + ONE_W;
                end
                if (pop && (occ_q == 2'd1) && !inflight_q && (cnt_q == len_q)) begin
                    state_d    = S_IDLE;
                    cnt_d      = '0;
                    run_done_d = 1'b1;
                end
            end

            S_FLUSH: begin
                collision_d = bus.ld_start | bus.run_start;
                state_d     = S_IDLE;
                run_done_d  = 1'b1;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        inflight_d = rd_en;
        occ_d      = occ_q + {1'b0, push} - {1'b0, pop};
        rd_ptr_d   = rd_ptr_q ^ pop;
        wr_ptr_d   = wr_ptr_q ^ push;
    end

    // State and control registers with synchronous active-high reset.
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            ld_count_q  <= '0;
            ld_done_q   <= 1'b0;
            run_done_q  <= 1'b0;
            collision_q <= 1'b0;
            inflight_q  <= 1'b0;
            occ_q       <= 2'd0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            ld_count_q  <= ld_count_d;
            ld_done_q   <= ld_done_d;
            run_done_q  <= run_done_d;
            collision_q <= collision_d;
            inflight_q  <= inflight_d;
            occ_q       <= occ_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
        end
    end

    // Capture the word returned by the memory one cycle after mem_re.
    // NOTE: FIFO storage is not reset; occupancy is, and rd_data is gated by rd_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= bus.mem_rdata;
        end
    end

    assign bus.ld_ready  = (state_q == S_LOAD);
    assign bus.ld_done   = ld_done_q;
    assign bus.ld_count  = ld_count_q;
    assign bus.rd_valid  = rd_valid_w;
    assign bus.rd_data   = rd_valid_w ? fifo_q[rd_ptr_q] : '0;
    assign bus.run_done  = run_done_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.collision = collision_q;
    assign bus.mem_we    = wr_en;
    assign bus.mem_re    = rd_en;
    assign bus.mem_addr  = (wr_en | rd_en) ? cnt_q[AW-1:0] : '0;
    assign bus.mem_wdata = wr_en ? bus.ld_data : '0;
endmodule
